div_ratio_meter: RTL and testbench

DIV_RATIO_METER -- requirements
Module: div_ratio_meter

---
 rtl/div_pkg.sv | 13 +
 rtl/edge_sync.sv | 37 +++
 rtl/div_ratio_meter.sv | 100 ++++++++++
 tb/tb_div_ratio_meter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared defaults and helpers for the divided-clock ratio meter.
package div_pkg;

    localparam int unsigned DefCntW       = 8;
    localparam int unsigned DefLockN      = 4;
    localparam int unsigned DefSyncStages = 2;

    // Saturation value of a width-bit period counter.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain for an asynchronous input plus a registered rising-edge detector.
module edge_sync
    import div_pkg::*;
#(
    parameter int unsigned STAGES = DefSyncStages
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic              rise_q, rise_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
        hist_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~hist_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/div_ratio_meter.sv
// Measures the period of a divided clock in system-clock cycles, flags lock on a run of
// equal periods and a timeout when no edge arrives before the counter saturates.
module div_ratio_meter
    import div_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned LOCK_N      = DefLockN,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned       MatchW    = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  CntMax    = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);
    localparam logic [MatchW-1:0] MatchFull = MatchW'(LOCK_N);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              armed_q, armed_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (clk_in),
        .rise (rise)
    );

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        match_d   = match_q;
        armed_d   = armed_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (rise) begin
            // An unarmed rise only marks the start of the first full period.
            cnt_d     = CntOne;
            armed_d   = 1'b1;
            timeout_d = 1'b0;
            if (armed_q) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
                if (cnt_q == period_q) begin
                    if (match_q != MatchFull) begin
                        match_d = match_q + MatchW'(1);
                    end
                end else begin
                    match_d = MatchW'(1);
                end
            end
        end else if (cnt_q == CntMax) begin
            timeout_d = 1'b1;
            armed_d   = 1'b0;
            match_d   = '0;
        end else begin
            cnt_d = cnt_q + CntOne;
        end
        locked_d = (match_d == MatchFull);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            period_q  <= '0;
            match_q   <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            match_q   <= match_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Self-checking bench for div_ratio_meter: scenario table, corner sequences and random
// waveforms, all compared cycle by cycle against an elapsed-time reference model.
module tb_div_ratio_meter;

    localparam int CNT_W  = 8;
    localparam int LOCK_N = 4;
    localparam int SYNC   = 2;
    localparam int MAXV   = 255;

    typedef struct {
        int n;
        int hi;
        int reps;
        int exp_period;
        bit exp_locked;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_in;
    logic             rise;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sample history, time since last rise, list of recent valid periods.
    bit samp_q[$];
    int vhist[$];
    bit m_rise, m_valid, m_locked, m_timeout, m_armed;
    int m_period, m_age;

    // Observed-behaviour bookkeeping.
    int step_no, last_rise_step;
    int n_rise, n_valid, lock_idx, last_vp, first_rise_step, to_step, rise_at_first_valid;
    bit lk_prev, to_prev, to_seen;

    vec_t tbl[6];

    div_ratio_meter #(
        .CNT_W       (CNT_W),
        .LOCK_N      (LOCK_N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_in       (clk_in),
        .rise         (rise),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        for (int i = 0; i < SYNC + 2; i++) samp_q.push_back(1'b0);
        vhist.delete();
        m_rise = 0; m_valid = 0; m_locked = 0; m_timeout = 0; m_armed = 0;
        m_period = 0; m_age = 0;
    endtask

    task automatic model_step(input bit v);
        m_valid = 1'b0;
        if (m_rise) begin
            if (m_armed) begin
                m_period = (m_age > MAXV) ? MAXV : m_age;
                m_valid  = 1'b1;
                vhist.push_back(m_period);
                if (vhist.size() > LOCK_N) void'(vhist.pop_front());
            end else begin
                vhist.delete();
            end
            m_armed = 1'b1; m_timeout = 1'b0; m_age = 1;
        end else begin
            if (m_age >= MAXV) begin
                m_timeout = 1'b1; m_armed = 1'b0; vhist.delete();
            end
            if (m_age < 100000) m_age++;
        end
        m_locked = 1'b0;
        if (vhist.size() == LOCK_N) begin
            m_locked = 1'b1;
            foreach (vhist[i]) if (vhist[i] != vhist[0]) m_locked = 1'b0;
        end
        samp_q.push_front(v);
        void'(samp_q.pop_back());
        m_rise = samp_q[SYNC] && !samp_q[SYNC+1];
    endtask

    task automatic clear_obs();
        n_rise = 0; n_valid = 0; lock_idx = 0; last_vp = 0; first_rise_step = 0;
        to_step = 0; rise_at_first_valid = 0; to_seen = 0;
        lk_prev = locked; to_prev = timeout;
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        clk_in = v;
        @(posedge clk);
        model_step(v);
        #1;
        step_no++;
        check("rise", rise, m_rise);
        check("period_valid", period_valid, m_valid);
        check("period", period, m_period);
        check("locked", locked, m_locked);
        check("timeout", timeout, m_timeout);
        if (rise) begin
            n_rise++;
            last_rise_step = step_no;
            if (first_rise_step == 0) first_rise_step = step_no;
        end
        if (period_valid) begin
            n_valid++;
            last_vp = period;
            if (n_valid == 1) rise_at_first_valid = n_rise;
        end
        if (locked && !lk_prev) lock_idx = n_valid;
        if (timeout && !to_prev) to_step = step_no;
        if (timeout) to_seen = 1'b1;
        lk_prev = locked;
        to_prev = timeout;
    endtask

    task automatic run_div(input int n, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++) step(i < hi);
    endtask

    // Called just after a step (posedge+1): asserts rst between clock edges.
    task automatic async_reset(input int hold);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_rise", rise, 0);
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{n: 8, hi: 4, reps: 6, exp_period: 8, exp_locked: 1'b1};
        tbl[1] = '{n: 6, hi: 3, reps: 5, exp_period: 6, exp_locked: 1'b1};
        tbl[2] = '{n: 2, hi: 1, reps: 8, exp_period: 2, exp_locked: 1'b1};
        tbl[3] = '{n: 5, hi: 2, reps: 6, exp_period: 5, exp_locked: 1'b1};
        tbl[4] = '{n: 7, hi: 1, reps: 3, exp_period: 7, exp_locked: 1'b0};
        tbl[5] = '{n: 3, hi: 2, reps: 6, exp_period: 3, exp_locked: 1'b1};

        step_no = 0; last_rise_step = 0;
        rst = 1'b1;
        clk_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rise", rise, 0);
        check("reset_period", period, 0);
        check("reset_valid", period_valid, 0);
        check("reset_locked", locked, 0);
        check("reset_timeout", timeout, 0);
        #1;
        rst = 1'b0;

        // Scenario table; entry 0 runs straight out of reset.
        for (int t = 0; t < 6; t++) begin
            clear_obs();
            run_div(tbl[t].n, tbl[t].hi, tbl[t].reps);
            check($sformatf("tbl%0d_period", t), last_vp, tbl[t].exp_period);
            check($sformatf("tbl%0d_locked", t), locked, tbl[t].exp_locked);
            if (t == 0) begin
                check("rise_latency", first_rise_step, SYNC + 1);
                check("div8_first_valid_rise", rise_at_first_valid, 2);
                check("div8_valid_count", n_valid, 5);
                check("div8_lock_idx", lock_idx, LOCK_N);
            end
        end

        // Hold clk_in low: timeout 255 edges after rise drops, i.e. 256 after rise shows.
        clear_obs();
        repeat (300) step(1'b0);
        check("timeout_delay", to_step - last_rise_step, 256);
        check("timeout_sticky", timeout, 1);
        check("timeout_unlocked", locked, 0);
        check("timeout_period_held", period, 3);

        // Next rise re-arms only.
        clear_obs();
        step(1'b1);
        repeat (7) step(1'b0);
        check("rearm_rises", n_rise, 1);
        check("rearm_no_valid", n_valid, 0);
        check("rearm_timeout_clr", timeout, 0);

        // Rises exactly MAX apart: capture wins over timeout.
        clear_obs();
        run_div(MAXV, 1, 3);
        check("max_valid_count", n_valid, 3);
        check("max_period", last_vp, MAXV);
        check("max_no_timeout", to_seen, 0);

        // Reset in the middle of a clk/8 low phase.
        run_div(8, 4, 3);
        repeat (4) step(1'b1);
        repeat (2) step(1'b0);
        clk_in = 1'b0;
        async_reset(3);
        clear_obs();
        repeat (2) step(1'b0);
        run_div(8, 4, 3);
        check("rst_first_valid_rise", rise_at_first_valid, 2);
        check("rst_first_period", last_vp, 8);
        check("rst_valid_count", n_valid, 2);

        // Random waveforms, occasional long idles and noise.
        for (int it = 0; it < 25; it++) begin
            int n, hi, reps;
            n    = $urandom_range(2, 16);
            hi   = $urandom_range(1, n - 1);
            reps = $urandom_range(2, 6);
            run_div(n, hi, reps);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(200, 300)) step(1'b0);
            if ($urandom_range(0, 5) == 0) repeat (12) step(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
